// File: rtl/tap_header_parser.sv
// tap_header_parser: validates the 20-byte C64 TAP header, latches version/length, forwards payload
//
// Ports
//    clk_i             clk_1_mhz stage clock
//    reset_ni          asynchronous active-low reset
//    restart_i         synchronous restart to header parse
//    data_valid_i      byte available from byteslicer
//    data_in_i [7:0]   byte from byteslicer
//    ack_o             byte taken from byteslicer (combinational)
//    data_valid_out_o  payload byte available to sample_assembler
//    byte_out_o [7:0]  payload byte
//    read_i            sample_assembler took byte_out_o
//    version_o [7:0]   latched header byte 12
//    data_len_o [31:0] latched header bytes 16..19, little-endian
//    hdr_ok_o          header accepted (PAYLOAD and DONE)
//    hdr_error_o       signature or version bad, sticky until restart/reset
//    tape_end_o        all payload bytes handed downstream
module tap_header_parser #(
   parameter bit         CHECK_SIG   = 1'b1,
   parameter logic [7:0] MAX_VERSION = 8'd2
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        restart_i,
   input  logic        data_valid_i,
   input  logic [7:0]  data_in_i,
   output logic        ack_o,
   output logic        data_valid_out_o,
   output logic [7:0]  byte_out_o,
   input  logic        read_i,
   output logic [7:0]  version_o,
   output logic [31:0] data_len_o,
   output logic        hdr_ok_o,
   output logic        hdr_error_o,
   output logic        tape_end_o
);
   typedef enum logic [1:0] {HDR, PAYLOAD, DONE, ERROR} state_e;
   // "C64-TAPE-RAW", padded to 16 entries so any 4-bit index is in range
   localparam logic [7:0] SIG [16] = '{8'h43, 8'h36, 8'h34, 8'h2d, 8'h54, 8'h41, 8'h50, 8'h45,
                                       8'h2d, 8'h52, 8'h41, 8'h57, 8'h00, 8'h00, 8'h00, 8'h00};
   state_e      state_q, state_d;
   logic [4:0]  hdr_cnt_q, hdr_cnt_d;
   logic        sig_bad_q, sig_bad_d;
   logic [7:0]  version_q, version_d;
   logic [31:0] data_len_q, data_len_d;
   logic [31:0] remaining_q, remaining_d;
   logic        buf_full_q, buf_full_d;
   logic [7:0]  buf_q, buf_d;
   logic        in_xfer, out_xfer;
   logic [31:0] len_full;
   assign ack_o = reset_ni & ~restart_i &
                  ((state_q == HDR) |
                   ((state_q == PAYLOAD) & (~buf_full_q | read_i) & (remaining_q != 32'd0)));
   assign in_xfer  = data_valid_i & ack_o;
   assign out_xfer = buf_full_q & read_i;
   // length including the byte being accepted as header byte 19
   assign len_full = {data_in_i, data_len_q[23:0]};
   always_comb begin
      state_d     = state_q;
      hdr_cnt_d   = hdr_cnt_q;
      sig_bad_d   = sig_bad_q;
      version_d   = version_q;
      data_len_d  = data_len_q;
      remaining_d = remaining_q;
      buf_full_d  = buf_full_q;
      buf_d       = buf_q;
      if (restart_i) begin
         state_d     = HDR;
         hdr_cnt_d   = 5'd0;
         sig_bad_d   = 1'b0;
         remaining_d = 32'd0;
         buf_full_d  = 1'b0;
         buf_d       = 8'h00;
      end else begin
         case (state_q)
            HDR: if (in_xfer) begin
               hdr_cnt_d = hdr_cnt_q + 5'd1;
               if (CHECK_SIG && hdr_cnt_q < 5'd12 && data_in_i != SIG[hdr_cnt_q[3:0]])
                  sig_bad_d = 1'b1;
               if (hdr_cnt_q == 5'd12)
                  version_d = data_in_i;
               if (hdr_cnt_q >= 5'd16)
                  data_len_d[{hdr_cnt_q[1:0], 3'b000} +: 8] = data_in_i;
               if (hdr_cnt_q == 5'd19) begin
                  hdr_cnt_d = 5'd0;
                  if (sig_bad_q || version_q > MAX_VERSION) begin
                     state_d = ERROR;
                  end else begin
                     remaining_d = len_full;
                     state_d     = (len_full == 32'd0) ? DONE : PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               // an accept overwrites the buffer; when it coincides with a read there is no bubble
               if (in_xfer) begin
                  buf_d       = data_in_i;
                  buf_full_d  = 1'b1;
                  remaining_d = remaining_q - 32'd1;
               end else if (out_xfer) begin
                  buf_full_d = 1'b0;
               end
               if (remaining_q == 32'd0 && !buf_full_q)
                  state_d = DONE;
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= HDR;
         hdr_cnt_q   <= 5'd0;
         sig_bad_q   <= 1'b0;
         version_q   <= 8'h00;
         data_len_q  <= 32'd0;
         remaining_q <= 32'd0;
         buf_full_q  <= 1'b0;
         buf_q       <= 8'h00;
      end else begin
         state_q     <= state_d;
         hdr_cnt_q   <= hdr_cnt_d;
         sig_bad_q   <= sig_bad_d;
         version_q   <= version_d;
         data_len_q  <= data_len_d;
         remaining_q <= remaining_d;
         buf_full_q  <= buf_full_d;
         buf_q       <= buf_d;
      end
   end
   assign data_valid_out_o = buf_full_q;
   assign byte_out_o       = buf_q;
   assign version_o        = version_q;
   assign data_len_o       = data_len_q;
   assign hdr_ok_o         = (state_q == PAYLOAD) | (state_q == DONE);
   assign hdr_error_o      = (state_q == ERROR);
   assign tape_end_o       = (state_q == DONE);
endmodule

// File: tb/tb_tap_header_parser.sv
// tb_tap_header_parser: randomized self-checking bench for tap_header_parser
module tb_tap_header_parser;
   typedef logic [7:0] bq_t[$];
   logic        clk = 1'b0, reset_n = 1'b0, restart = 1'b0, dv = 1'b0, rd = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        ack, dvo, hok, herr, tend;
   logic [7:0]  bout, ver;
   logic [31:0] dlen;
   logic        ack1, dvo1, hok1, herr1, tend1;
   logic [7:0]  bout1, ver1;
   logic [31:0] dlen1;
   int          tests = 0, fails = 0;
   string       sig_s = "C64-TAPE-RAW";
   bq_t         stream, got;
   int          acc_cyc[$], out_cyc[$];
   int          n_acked = 0, cyc = 0;

   always #5 clk = ~clk;

   tap_header_parser dut (
      .clk_i(clk), .reset_ni(reset_n), .restart_i(restart), .data_valid_i(dv), .data_in_i(din),
      .ack_o(ack), .data_valid_out_o(dvo), .byte_out_o(bout), .read_i(rd), .version_o(ver),
      .data_len_o(dlen), .hdr_ok_o(hok), .hdr_error_o(herr), .tape_end_o(tend));

   tap_header_parser #(.CHECK_SIG(1'b0)) dut_ns (
      .clk_i(clk), .reset_ni(reset_n), .restart_i(restart), .data_valid_i(dv), .data_in_i(din),
      .ack_o(ack1), .data_valid_out_o(dvo1), .byte_out_o(bout1), .read_i(rd), .version_o(ver1),
      .data_len_o(dlen1), .hdr_ok_o(hok1), .hdr_error_o(herr1), .tape_end_o(tend1));

   function automatic void build(input logic [7:0] v, input int len, input int bad, input int extra);
      stream.delete();
      for (int i = 0; i < 12; i++) stream.push_back(sig_s[i]);
      if (bad >= 0) stream[bad] = 8'h58;
      stream.push_back(v);
      for (int i = 0; i < 3; i++) stream.push_back(8'($urandom_range(255)));
      for (int i = 0; i < 4; i++) stream.push_back(8'(len >> (8 * i)));
      for (int i = 0; i < len + extra; i++) stream.push_back(8'($urandom_range(255)));
   endfunction

   function automatic void model(input bit chk, output bit err, output logic [7:0] v, output logic [31:0] l);
      bit sb = 0;
      for (int i = 0; i < 12; i++) if (stream[i] != sig_s[i]) sb = 1;
      v   = stream[12];
      l   = {stream[19], stream[18], stream[17], stream[16]};
      err = (chk && sb) || v > 8'd2;
   endfunction

   function automatic bq_t exp_of(input int len);
      bq_t q;
      for (int i = 0; i < len; i++) q.push_back(stream[20 + i]);
      return q;
   endfunction

   function automatic bit same(input bq_t a, input bq_t b);
      if (a.size() != b.size()) return 0;
      foreach (a[i]) if (a[i] !== b[i]) return 0;
      return 1;
   endfunction

   task automatic step(input int vp, input int rp);
      @(negedge clk);
      dv  = (n_acked < stream.size()) && ($urandom_range(99) < vp);
      din = (n_acked < stream.size()) ? stream[n_acked] : 8'($urandom_range(255));
      rd  = (rp < 0) ? cyc[0] : ($urandom_range(99) < rp);
      #1;
      if (dv && ack) begin
         if (n_acked >= 20) acc_cyc.push_back(cyc);
         n_acked++;
      end
      if (dvo && rd) begin
         got.push_back(bout);
         out_cyc.push_back(cyc);
      end
      cyc++;
   endtask

   task automatic do_restart();
      @(negedge clk);
      dv = 1'b0;
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic run_file(input int vp, input int rp, output bit tmo);
      n_acked = 0;
      got.delete();
      acc_cyc.delete();
      out_cyc.delete();
      tmo = 1;
      for (int b = 0; b < 2000; b++) begin
         step(vp, rp);
         if (tend || herr) begin
            tmo = 0;
            break;
         end
      end
      for (int i = 0; i < 8; i++) step(100, 100);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests++;
      if ({ack, dvo, bout, ver, dlen, hok, herr, tend} !== 52'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %h, expected 0", {ack, dvo, bout, ver, dlen, hok, herr, tend});
      end
      reset_n = 1'b1;
   endtask

   task automatic test_valid_v1();
      bit tmo;
      bq_t exp = '{8'h30, 8'h2f, 8'h00, 8'h12, 8'h34};
      logic [7:0] pl [6] = '{8'h30, 8'h2f, 8'h00, 8'h12, 8'h34, 8'h56};
      build(8'd1, 5, -1, 1);
      for (int i = 0; i < 6; i++) stream[20 + i] = pl[i];
      do_restart();
      run_file(100, 100, tmo);
      tests++;
      if (tmo || {hok, herr, tend} !== 3'b101) begin
         fails++;
         $display("FAIL v1_flags: tmo=%0d hok/herr/tend=%b, expected 101", tmo, {hok, herr, tend});
      end
      tests++;
      if (ver !== 8'd1 || dlen !== 32'd5) begin
         fails++;
         $display("FAIL v1_latch: version=%0d len=%0d, expected 1 5", ver, dlen);
      end
      tests++;
      if (!same(got, exp)) begin
         fails++;
         $display("FAIL v1_payload: %0d bytes got, expected 30 2f 00 12 34", got.size());
      end
      tests++;
      if (n_acked != 25) begin
         fails++;
         $display("FAIL v1_no_surplus_ack: acked %0d, expected 25", n_acked);
      end
   endtask

   task automatic test_bad_sig();
      bit tmo;
      build(8'd1, 4, 3, 2);
      do_restart();
      run_file(100, 100, tmo);
      tests++;
      if (tmo || {hok, herr, tend} !== 3'b010 || got.size() != 0 || n_acked != 20) begin
         fails++;
         $display("FAIL sig_error: hok/herr/tend=%b fwd=%0d acked=%0d, expected 010 0 20",
                  {hok, herr, tend}, got.size(), n_acked);
      end
      tests++;
      if (hok1 !== 1'b1 || herr1 !== 1'b0) begin
         fails++;
         $display("FAIL sig_unchecked: hok=%b herr=%b, expected 1 0", hok1, herr1);
      end
   endtask

   task automatic test_version();
      bit tmo;
      build(8'd3, 4, -1, 1);
      do_restart();
      run_file(100, 100, tmo);
      tests++;
      if (tmo || herr !== 1'b1 || hok !== 1'b0 || got.size() != 0) begin
         fails++;
         $display("FAIL version3: herr=%b hok=%b fwd=%0d, expected 1 0 0", herr, hok, got.size());
      end
      build(8'd2, 3, -1, 1);
      do_restart();
      run_file(100, 100, tmo);
      tests++;
      if (tmo || hok !== 1'b1 || ver !== 8'd2 || !same(got, exp_of(3))) begin
         fails++;
         $display("FAIL version2: hok=%b ver=%0d fwd=%0d, expected 1 2 3", hok, ver, got.size());
      end
   endtask

   task automatic test_zero_len();
      bit tmo;
      build(8'd0, 0, -1, 3);
      do_restart();
      run_file(100, 100, tmo);
      tests++;
      if (tmo || {hok, tend} !== 2'b11 || got.size() != 0 || n_acked != 20 || dlen !== 32'd0) begin
         fails++;
         $display("FAIL zero_len: hok/tend=%b fwd=%0d acked=%0d len=%0d, expected 11 0 20 0",
                  {hok, tend}, got.size(), n_acked, dlen);
      end
   endtask

   task automatic test_back_to_back();
      bit tmo, consec, lat;
      build(8'd1, 8, -1, 2);
      do_restart();
      run_file(100, 100, tmo);
      consec = (acc_cyc.size() == 8);
      lat = (out_cyc.size() == acc_cyc.size());
      for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] != acc_cyc[0] + i) consec = 0;
      for (int i = 0; i < out_cyc.size() && i < acc_cyc.size(); i++)
         if (out_cyc[i] != acc_cyc[i] + 1) lat = 0;
      tests++;
      if (tmo || !same(got, exp_of(8))) begin
         fails++;
         $display("FAIL b2b_data: fwd=%0d, expected 8 matching bytes", got.size());
      end
      tests++;
      if (!consec || !lat) begin
         fails++;
         $display("FAIL b2b_timing: consecutive=%0d latency1=%0d, expected 1 1", consec, lat);
      end
      build(8'd1, 8, -1, 2);
      do_restart();
      run_file(100, -1, tmo);
      tests++;
      if (tmo || !same(got, exp_of(8)) || tend !== 1'b1) begin
         fails++;
         $display("FAIL toggle_read: fwd=%0d tend=%b, expected 8 1", got.size(), tend);
      end
   endtask

   task automatic test_restart();
      bit tmo;
      build(8'd2, 10, -1, 2);
      do_restart();
      n_acked = 0;
      got.delete();
      for (int b = 0; b < 200 && got.size() < 3; b++) step(100, 100);
      @(negedge clk);
      restart = 1'b1;
      dv = 1'b1;
      din = stream[n_acked];
      rd = 1'b0;
      #1;
      tests++;
      if (ack !== 1'b0 || got.size() != 3) begin
         fails++;
         $display("FAIL restart_blocks_ack: ack=%b fwd=%0d, expected 0 3", ack, got.size());
      end
      @(negedge clk);
      restart = 1'b0;
      dv = 1'b0;
      #1;
      tests++;
      if ({dvo, hok, tend, herr, ack} !== 5'b00001 || ver !== 8'd2 || dlen !== 32'd10) begin
         fails++;
         $display("FAIL restart_state: dvo/hok/tend/herr/ack=%b ver=%0d len=%0d, expected 00001 2 10",
                  {dvo, hok, tend, herr, ack}, ver, dlen);
      end
      build(8'd0, 3, -1, 1);
      run_file(80, 70, tmo);
      tests++;
      if (tmo || hok !== 1'b1 || ver !== 8'd0 || dlen !== 32'd3 || !same(got, exp_of(3))) begin
         fails++;
         $display("FAIL restart_reparse: hok=%b ver=%0d len=%0d fwd=%0d, expected 1 0 3 3",
                  hok, ver, dlen, got.size());
      end
   endtask

   task automatic test_random();
      bit tmo, err, errn;
      logic [7:0] v, vn;
      logic [31:0] l, ln;
      int len;
      for (int it = 0; it < 24; it++) begin
         len = $urandom_range(12);
         build(8'($urandom_range(3)), len, ($urandom_range(3) == 0) ? int'($urandom_range(11)) : -1,
               $urandom_range(3));
         model(1'b1, err, v, l);
         model(1'b0, errn, vn, ln);
         do_restart();
         run_file($urandom_range(100, 30), $urandom_range(100, 20), tmo);
         tests++;
         if (tmo || herr !== err || hok !== !err) begin
            fails++;
            $display("FAIL rand%0d_status: tmo=%0d herr=%b hok=%b, expected herr=%b", it, tmo, herr, hok, err);
         end
         tests++;
         if (err ? (got.size() != 0 || n_acked != 20)
                 : (ver !== v || dlen !== l || !same(got, exp_of(len)) || n_acked != 20 + len)) begin
            fails++;
            $display("FAIL rand%0d_data: ver=%0d len=%0d fwd=%0d acked=%0d, expected ver=%0d len=%0d err=%0d",
                     it, ver, dlen, got.size(), n_acked, v, l, err);
         end
         tests++;
         if (hok1 !== !errn || herr1 !== errn) begin
            fails++;
            $display("FAIL rand%0d_nosig: hok=%b herr=%b, expected herr=%b", it, hok1, herr1, errn);
         end
      end
   endtask

   task automatic test_async_reset();
      bit tmo;
      build(8'd1, 4, -1, 0);
      do_restart();
      n_acked = 0;
      got.delete();
      for (int i = 0; i < 7; i++) step(100, 0);
      #2;
      reset_n = 1'b0;
      #1;
      tests++;
      if ({ack, dvo, bout, ver, dlen, hok, herr, tend} !== 52'd0 ||
          {ack1, dvo1, bout1, ver1, dlen1, hok1, herr1, tend1} !== 52'd0) begin
         fails++;
         $display("FAIL async_reset: got %h / %h, expected 0",
                  {ack, dvo, bout, ver, dlen, hok, herr, tend},
                  {ack1, dvo1, bout1, ver1, dlen1, hok1, herr1, tend1});
      end
      @(negedge clk);
      dv = 1'b0;
      reset_n = 1'b1;
      build(8'd2, 2, -1, 1);
      run_file(100, 100, tmo);
      tests++;
      if (tmo || hok !== 1'b1 || !same(got, exp_of(2))) begin
         fails++;
         $display("FAIL post_reset_parse: hok=%b fwd=%0d, expected 1 2", hok, got.size());
      end
   endtask

   initial begin
      test_reset();
      test_valid_v1();
      test_bad_sig();
      test_version();
      test_zero_len();
      test_back_to_back();
      test_restart();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
